writeback_scheduler: RTL

- Arbitrates result write-back from the four execution groups (load_move_logic, arithmetic, slowArithmetic, memory) onto the single register-file write port.
- Each group has a one-entry holding buffer. Pending buffers are granted round-robin, one per cycle.
- Keeps a per-register pending scoreboard so fetch logic can stall on results of indeterminate latency (chiefly memory).
- Sits between the execution units and the register file, beside register fetch.

---
 rtl/writeback_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/writeback_scheduler.sv
// Write-back arbiter: four one-entry holding buffers, round-robin onto one
// register-file write port, plus a per-register pending scoreboard.
module writeback_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    load_move_logic_value,
  input  logic [ADDR_W-1:0]    load_move_logic_dest,
  input  logic                 load_move_logic_done,
  output logic                 load_move_logic_full,
  input  logic [DATA_W-1:0]    arithmetic_value,
  input  logic [ADDR_W-1:0]    arithmetic_dest,
  input  logic                 arithmetic_done,
  output logic                 arithmetic_full,
  input  logic [DATA_W-1:0]    slowArithmetic_value,
  input  logic [ADDR_W-1:0]    slowArithmetic_dest,
  input  logic                 slowArithmetic_done,
  output logic                 slowArithmetic_full,
  input  logic [DATA_W-1:0]    memory_value,
  input  logic [ADDR_W-1:0]    memory_dest,
  input  logic                 memory_done,
  output logic                 memory_full,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_dest,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [(1<<ADDR_W)-1:0] reg_pending,
  output logic                 overflow
);
  localparam int unsigned NSRC = 4;
  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] in_value [NSRC];
  logic [ADDR_W-1:0] in_dest  [NSRC];
  logic [NSRC-1:0]   in_done;

  logic [NSRC-1:0]   buf_valid;
  logic [DATA_W-1:0] buf_data [NSRC];
  logic [ADDR_W-1:0] buf_dest [NSRC];
  logic [1:0]        ptr;

  logic [NSRC-1:0]   grant;
  logic [NSRC-1:0]   full;
  logic              gany;
  logic [1:0]        gidx;
  logic [1:0]        idx;
  logic [NREG-1:0]   pend_next;

  assign in_value[0] = load_move_logic_value;
  assign in_value[1] = arithmetic_value;
  assign in_value[2] = slowArithmetic_value;
  assign in_value[3] = memory_value;
  assign in_dest[0]  = load_move_logic_dest;
  assign in_dest[1]  = arithmetic_dest;
  assign in_dest[2]  = slowArithmetic_dest;
  assign in_dest[3]  = memory_dest;
  assign in_done     = {memory_done, slowArithmetic_done, arithmetic_done, load_move_logic_done};

  assign full                 = buf_valid & ~grant;
  assign load_move_logic_full = full[0];
  assign arithmetic_full      = full[1];
  assign slowArithmetic_full  = full[2];
  assign memory_full          = full[3];

  // Round-robin search starting just after the last granted source.
  always_comb begin
    grant = '0;
    gany  = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 1; k <= int'(NSRC); k++) begin
      idx = ptr + 2'(k);
      if (!gany && buf_valid[idx]) begin
        gany = 1'b1;
        gidx = idx;
      end
    end
    if (gany) grant[gidx] = 1'b1;
  end

  // A new issue outranks a retiring write to the same register.
  always_comb begin
    pend_next = reg_pending;
    if (gany) pend_next[buf_dest[gidx]] = 1'b0;
    if (issue_valid) pend_next[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid   <= '0;
      ptr         <= 2'd3;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      reg_pending <= '0;
      overflow    <= 1'b0;
      for (int i = 0; i < int'(NSRC); i++) begin
        buf_data[i] <= '0;
        buf_dest[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NSRC); i++) begin
        if (in_done[i] && !full[i]) begin
          buf_valid[i] <= 1'b1;
          buf_data[i]  <= in_value[i];
          buf_dest[i]  <= in_dest[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      if (|(in_done & full)) overflow <= 1'b1;
      rf_we <= gany;
      if (gany) begin
        ptr      <= gidx;
        rf_waddr <= buf_dest[gidx];
        rf_wdata <= buf_data[gidx];
      end
      reg_pending <= pend_next;
    end
  end
endmodule
